// File: rtl/div_if.sv
// div_if: request/response bundle between the CPU datapath and the divider
interface div_if #(parameter int WIDTH = 32);
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               start;
    logic               is_signed;
    logic               busy;
    logic               divfinish;
    logic               div_by_zero;
    logic [2*WIDTH-1:0] y;
    modport master (output a, b, start, is_signed, input busy, divfinish, div_by_zero, y);
    modport slave (input a, b, start, is_signed, output busy, divfinish, div_by_zero, y);
endinterface

// File: rtl/div_unit.sv
// div_unit: sequential restoring divider for div/divu, one quotient bit per clock;
// defining DIV_EARLY_OUT_EN finishes in one edge when |a| < |b|
module div_unit #(
    parameter int WIDTH = 32
) (
    input logic  clk,
    input logic  rst_n,
    div_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
    state_t             state_q, state_d;
    logic [WIDTH-1:0]   rem_q, quo_q, dvsr_q, abs_a, abs_b;
    logic [CW-1:0]      cnt_q;
    logic               sgn_quo_q, sgn_rem_q, dbz_q;
    logic [WIDTH:0]     trial;
    logic               b_zero, early;
    logic [2*WIDTH-1:0] y_q;
    logic               fin_q, dbz_out_q;
    assign abs_a = (bus.is_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign abs_b = (bus.is_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    assign b_zero = (bus.b == '0);
    assign trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvsr_q};
`ifdef DIV_EARLY_OUT_EN
    assign early = !b_zero && (abs_a < abs_b);
`else
    assign early = 1'b0;
`endif
    assign bus.busy = (state_q != IDLE);
    assign bus.y = y_q;
    assign bus.divfinish = fin_q;
    assign bus.div_by_zero = dbz_out_q;
    // next state: launch from IDLE, iterate WIDTH times, one FIX edge to publish
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = bus.start ? ((b_zero || early) ? FIX : CALC) : IDLE;
            CALC:    state_d = (cnt_q == CW'(1)) ? FIX : CALC;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    // state register and datapath; the divide-by-zero result is preloaded so FIX needs no special case
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rem_q     <= '0;
            quo_q     <= '0;
            dvsr_q    <= '0;
            cnt_q     <= '0;
            sgn_quo_q <= 1'b0;
            sgn_rem_q <= 1'b0;
            dbz_q     <= 1'b0;
            y_q       <= '0;
            fin_q     <= 1'b0;
            dbz_out_q <= 1'b0;
        end else begin
            state_q <= state_d;
            fin_q   <= 1'b0;
            case (state_q)
                IDLE: if (bus.start) begin
                    dvsr_q    <= abs_b;
                    cnt_q     <= CW'(WIDTH);
                    dbz_q     <= b_zero;
                    rem_q     <= b_zero ? bus.a : (early ? abs_a : '0);
                    quo_q     <= b_zero ? '1 : (early ? '0 : abs_a);
                    sgn_quo_q <= !b_zero && bus.is_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                    sgn_rem_q <= !b_zero && bus.is_signed && bus.a[WIDTH-1];
                end
                CALC: begin
                    rem_q <= trial[WIDTH] ? {rem_q[WIDTH-2:0], quo_q[WIDTH-1]} : trial[WIDTH-1:0];
                    quo_q <= {quo_q[WIDTH-2:0], !trial[WIDTH]};
                    cnt_q <= cnt_q - CW'(1);
                end
                FIX: begin
                    y_q       <= {sgn_rem_q ? -rem_q : rem_q, sgn_quo_q ? -quo_q : quo_q};
                    fin_q     <= 1'b1;
                    dbz_out_q <= dbz_q;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
Sequential restoring divider; the inverse companion of the shift-add multiplier in the MIPS-style datapath. Produces quotient (mflo) and remainder (mfhi) for div/divu, one quotient bit per clock. Handshake mirrors the multiplier: a start pulse launches the operation and a finish pulse returns the result. The CPU stalls mfhi/mflo on busy.

Parameters:
WIDTH, 32, operand width; y is 2*WIDTH.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
a  input  WIDTH  dividend
b  input  WIDTH  divisor
start  input  1  launch request, sampled only in IDLE
is_signed  input  1  1 = div (two's complement), 0 = divu
busy  output  1  high while an operation is in flight (state != IDLE)
divfinish  output  1  one-cycle pulse when y is updated
div_by_zero  output  1  registered with y; high if the last op had b == 0
y  output  2*WIDTH  {remainder, quotient}; hi half = mfhi, lo half = mflo

Behaviour:
- Reset: synchronous on rst_n == 0 at a clk edge. State becomes IDLE. y = 0, divfinish = 0, busy = 0, div_by_zero = 0. Reset mid-operation aborts the operation with no finish pulse.
- States:
  - IDLE: on start == 1, latch operands.
    - If b == 0, go to FIX.
    - Otherwise load |a| and |b| (magnitudes only when is_signed == 1), record sign_q = a[msb]^b[msb] and sign_r = a[msb] (both 0 for unsigned), set count = WIDTH, go to CALC.
  - CALC: one restoring step per edge.
    - Shift {rem, quo} left by 1.
    - trial = rem - divisor, computed WIDTH+1 bits wide.
    - If trial is non-negative: rem = trial, quo[0] = 1. Otherwise quo[0] = 0.
    - Decrement count; on the edge where count reaches 0, go to FIX.
  - FIX: one edge.
    - Quotient = sign_q ? -quo : quo. Remainder = sign_r ? -rem : rem.
    - Register y = {remainder, quotient}, pulse divfinish = 1, register div_by_zero, return to IDLE.
- Divide by zero: quotient = all ones (0xFFFFFFFF), remainder = a unmodified, div_by_zero = 1. Applies regardless of is_signed.
- Signed overflow (0x80000000 / 0xFFFFFFFF, signed): quotient = 0x80000000, remainder = 0, div_by_zero = 0. This falls out of the magnitude/negate path with no special case.
- Latency, with start sampled at edge E0:
  - Normal op: divfinish high for the cycle after edge E(WIDTH+1), i.e. 33 edges for WIDTH = 32. busy is high from E0 until that same edge.
  - Divide by zero: divfinish after E1.
- divfinish is high exactly one cycle. y and div_by_zero hold their values until the next FIX or reset.
- start while busy is ignored. start on the same edge FIX completes is also ignored; the new op needs start in IDLE.
- a, b and is_signed are only sampled at launch and may change freely afterwards.
- Remainder sign follows the dividend. Quotient truncates toward zero.

Optional Feature:
DIV_EARLY_OUT_EN
- Defined: in IDLE, if b != 0 and |a| < |b| (unsigned compare of magnitudes), go directly to FIX with quo = 0 and rem = |a|. Result is y = {a, 0}, latency 1 edge.
- Undefined: this case runs the full WIDTH iterations. The result is bit-identical; only latency differs.

Test Plan:
- Unsigned: a = 100, b = 7, is_signed = 0 -> y = 0x00000002_0000000E, divfinish one cycle after edge 33, busy low afterwards.
- Signed: a = 0xFFFFFFF9 (-7), b = 2 -> y = 0xFFFFFFFF_FFFFFFFD (r = -1, q = -3). Also a = 7, b = 0xFFFFFFFE (-2) -> y = 0x00000001_FFFFFFFD.
- Divide by zero: a = 5, b = 0, either is_signed -> y = 0x00000005_FFFFFFFF, div_by_zero = 1, divfinish after 1 edge. A following op 9/3 -> div_by_zero = 0, y = 0x00000000_00000003.
- Overflow and divu of large values:
  - Signed 0x80000000 / 0xFFFFFFFF -> y = 0x00000000_80000000.
  - Unsigned 0xFFFFFFFF / 0x10 -> y = 0x0000000F_0FFFFFFF.
- Reset and start-while-busy:
  - rst_n low at edge 10 of an operation -> busy, divfinish and y all 0, with no finish pulse.
  - Pulsing start with different operands mid-op -> ignored; original result returned.
  - After reset, 100/7 completes correctly.
- Early-out: 3 / 10 -> y = 0x00000003_00000000. With DIV_EARLY_OUT_EN defined, divfinish comes after 1 edge; without it, after 33 edges.
